hazard_controller: RTL and testbench

Pipeline sequencing controller for the five-stage LC-3b core.
- Decides each cycle which pipeline registers advance, freeze or take a bubble.
- Detects load-use hazards that the forwarding network cannot cover.
- Freezes the pipeline on instruction- or data-memory wait.
- Flushes younger stages on a taken branch resolved in MEM.
- Sequences the two data-memory accesses of LDI/STI.
- Sits beside the forwarding unit and drives the load/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.

---
 rtl/hazard_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_hazard_controller.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing controller for the five-stage LC-3b core. Each cycle it
//   decides which pipeline registers advance, freeze or take a bubble. It
//   detects load-use hazards, freezes on instruction/data memory wait, flushes
//   younger stages on a taken branch resolved in MEM, and sequences the two
//   data-memory accesses of LDI/STI.
//
//   Optional build macro: HAZARD_PERF_EN adds the stall_cycles and
//   bubble_count performance counters and their ports.
//
// Ports
//   clk, rst              pipeline clock, synchronous active-high reset
//   id_sr1_id/id_sr2_id   source registers of the ID instruction (lc3b_reg, 3 bits)
//   id_uses_sr1/sr2       ID instruction really reads that source
//   ex_dest               destination register of the EX instruction
//   ex_is_load            EX instruction is LDR/LDB/LDI
//   ex_load_regfile       EX instruction writes the regfile
//   imem_read/imem_resp   fetch outstanding / fetch completes this cycle
//   mem_req               MEM instruction accesses data memory
//   mem_write             MEM access is a store (final access for STI)
//   mem_indirect          MEM instruction is LDI/STI
//   dmem_resp             data access completes this cycle
//   br_taken              MEM resolved a taken branch/jump
//   dmem_read/dmem_write  data-memory strobes
//   mem_addr_sel          0 = computed address, 1 = indirect pointer register
//   ind_latch             capture first-access read data into the pointer reg
//   load_*                pipeline register / PC advance enables
//   flush_*               load a bubble instead of upstream data
//   pc_target_sel         PC mux selects the branch target
//   stall_cycles          (HAZARD_PERF_EN) saturating count of stalled cycles
//   bubble_count          (HAZARD_PERF_EN) saturating count of applied bubbles/flushes
//
// MEM access FSM
//   state    | meaning
//   M_FIRST  | plain access, or first (pointer) access of LDI/STI
//   M_SECOND | second access of LDI/STI through the pointer register

module hazard_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] id_sr1_id,
    input  logic [2:0] id_sr2_id,
    input  logic       id_uses_sr1,
    input  logic       id_uses_sr2,
    input  logic [2:0] ex_dest,
    input  logic       ex_is_load,
    input  logic       ex_load_regfile,
    input  logic       imem_read,
    input  logic       imem_resp,
    input  logic       mem_req,
    input  logic       mem_write,
    input  logic       mem_indirect,
    input  logic       dmem_resp,
    input  logic       br_taken,
    output logic       dmem_read,
    output logic       dmem_write,
    output logic       mem_addr_sel,
    output logic       ind_latch,
    output logic       load_pc,
    output logic       load_if_id,
    output logic       load_id_ex,
    output logic       load_ex_mem,
    output logic       load_mem_wb,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       flush_ex_mem,
    output logic       pc_target_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] bubble_count
`endif
);

    typedef enum logic {
        M_FIRST  = 1'b0,
        M_SECOND = 1'b1
    } mem_state_e;

    mem_state_e state_q;
    mem_state_e state_d;

    logic dmem_busy;
    logic imem_busy;
    logic stall;
    logic load_use;
    logic ind_first_done;
    logic rd_raw;
    logic wr_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_addr_sel   = 1'b0;
        rd_raw         = 1'b0;
        wr_raw         = 1'b0;
        ind_first_done = 1'b0;

        case (state_q)
            M_FIRST: begin
                mem_addr_sel = 1'b0;
                // The pointer fetch of LDI/STI is always a read.
                rd_raw = mem_req & (mem_indirect | ~mem_write);
                wr_raw = mem_req & ~mem_indirect & mem_write;
                if (mem_req && mem_indirect && dmem_resp) begin
                    ind_first_done = 1'b1;
                    state_d        = M_SECOND;
                end
            end
            M_SECOND: begin
                mem_addr_sel = 1'b1;
                rd_raw       = ~mem_write;
                wr_raw       = mem_write;
                if (dmem_resp) begin
                    state_d = M_FIRST;
                end
            end
            default: begin
                state_d = M_FIRST;
            end
        endcase
    end

    // Only the final access of an access sequence releases the pipe.
    assign dmem_busy = mem_req & ~(dmem_resp & ((state_q == M_SECOND) | ~mem_indirect));
    assign imem_busy = imem_read & ~imem_resp;
    assign stall     = dmem_busy | imem_busy;
    assign load_use  = ex_is_load & ex_load_regfile &
                       ((id_uses_sr1 & (ex_dest == id_sr1_id)) |
                        (id_uses_sr2 & (ex_dest == id_sr2_id)));

    always_comb begin
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        ind_latch     = 1'b0;
        load_pc       = 1'b0;
        load_if_id    = 1'b0;
        load_id_ex    = 1'b0;
        load_ex_mem   = 1'b0;
        load_mem_wb   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        pc_target_sel = 1'b0;

        if (!rst) begin
            dmem_read  = rd_raw;
            dmem_write = wr_raw;
            // The latch happens even while imem holds the pipe frozen, so the
            // second access never re-fetches the pointer.
            ind_latch  = ind_first_done;

            if (stall) begin
                // Whole pipe frozen; branch and load-use inputs hold, so
                // their effects are simply applied later.
            end else if (br_taken) begin
                load_pc       = 1'b1;
                load_if_id    = 1'b1;
                load_id_ex    = 1'b1;
                load_ex_mem   = 1'b1;
                load_mem_wb   = 1'b1;
                flush_if_id   = 1'b1;
                flush_id_ex   = 1'b1;
                flush_ex_mem  = 1'b1;
                pc_target_sel = 1'b1;
            end else if (load_use) begin
                load_id_ex  = 1'b1;
                flush_id_ex = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;
    logic [15:0] bubble_count_q;
    logic [15:0] bubble_count_d;
    logic        bubble_applied;

    assign bubble_applied = ~stall & (br_taken | load_use);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_count_d = bubble_count_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (bubble_applied && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 16'd0;
            bubble_count_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_sr1_id, id_sr2_id, ex_dest;
    logic       id_uses_sr1, id_uses_sr2, ex_is_load, ex_load_regfile;
    logic       imem_read, imem_resp, mem_req, mem_write, mem_indirect, dmem_resp, br_taken;
    logic       dmem_read, dmem_write, mem_addr_sel, ind_latch;
    logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, pc_target_sel;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, bubble_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [4:0] loads;
    logic [2:0] flushes;
    assign loads   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    assign flushes = {flush_if_id, flush_id_ex, flush_ex_mem};

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk(clk), .rst(rst),
        .id_sr1_id(id_sr1_id), .id_sr2_id(id_sr2_id),
        .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
        .ex_dest(ex_dest), .ex_is_load(ex_is_load), .ex_load_regfile(ex_load_regfile),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .mem_req(mem_req), .mem_write(mem_write), .mem_indirect(mem_indirect),
        .dmem_resp(dmem_resp), .br_taken(br_taken),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .mem_addr_sel(mem_addr_sel), .ind_latch(ind_latch),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .pc_target_sel(pc_target_sel)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .bubble_count(bubble_count)
`endif
    );

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_sr1_id = 3'd0; id_sr2_id = 3'd0; ex_dest = 3'd0;
        id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0;
        ex_is_load = 1'b0; ex_load_regfile = 1'b0;
        imem_read = 1'b0; imem_resp = 1'b0;
        mem_req = 1'b0; mem_write = 1'b0; mem_indirect = 1'b0;
        dmem_resp = 1'b0; br_taken = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1; mem_req = 1'b1; br_taken = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b00000 || flushes !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctl loads=%b flushes=%b exp 00000/000", loads, flushes);
        end
        checks++;
        if ({dmem_read, dmem_write, ind_latch, pc_target_sel} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes rd/wr/lat/pcsel=%b exp 0000",
                     {dmem_read, dmem_write, ind_latch, pc_target_sel});
        end
        tick();
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 3'b000 || mem_addr_sel !== 1'b0) begin
            failures++;
            $display("FAIL idle_advance loads=%b flushes=%b sel=%b exp 11111/000/0",
                     loads, flushes, mem_addr_sel);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd3;
        id_sr1_id = 3'd3; id_uses_sr1 = 1'b1; id_sr2_id = 3'd5;
        #1;
        checks++;
        if (loads !== 5'b00111 || flushes !== 3'b010) begin
            failures++;
            $display("FAIL load_use_sr1 loads=%b flushes=%b exp 00111/010", loads, flushes);
        end
        tick();
        // Load has moved to MEM; ID now holds the consumer with no hazard.
        ex_is_load = 1'b0; ex_load_regfile = 1'b0;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 3'b000) begin
            failures++;
            $display("FAIL load_use_after loads=%b flushes=%b exp 11111/000", loads, flushes);
        end
        tick();
        ex_is_load = 1'b1; ex_load_regfile = 1'b1; id_uses_sr1 = 1'b0;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 3'b000) begin
            failures++;
            $display("FAIL load_use_unused loads=%b flushes=%b exp 11111/000", loads, flushes);
        end
        tick();
        id_sr2_id = 3'd3; id_uses_sr2 = 1'b1; id_sr1_id = 3'd1;
        #1;
        checks++;
        if (loads !== 5'b00111 || flushes !== 3'b010) begin
            failures++;
            $display("FAIL load_use_sr2 loads=%b flushes=%b exp 00111/010", loads, flushes);
        end
        tick();
        ex_load_regfile = 1'b0;
        #1;
        checks++;
        if (loads !== 5'b11111) begin
            failures++;
            $display("FAIL load_use_nowrite loads=%b exp 11111", loads);
        end
        tick();
        set_idle();
    endtask

    task automatic test_plain_access();
        set_idle();
        mem_req = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b00000 || {dmem_read, dmem_write} !== 2'b10) begin
            failures++;
            $display("FAIL load_wait loads=%b rd/wr=%b exp 00000/10", loads, {dmem_read, dmem_write});
        end
        tick();
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111 || dmem_read !== 1'b1 || ind_latch !== 1'b0) begin
            failures++;
            $display("FAIL load_resp loads=%b rd=%b lat=%b exp 11111/1/0", loads, dmem_read, ind_latch);
        end
        tick();
        mem_write = 1'b1; dmem_resp = 1'b0;
        #1;
        checks++;
        if ({dmem_read, dmem_write} !== 2'b01 || loads !== 5'b00000) begin
            failures++;
            $display("FAIL store_wait rd/wr=%b loads=%b exp 01/00000", {dmem_read, dmem_write}, loads);
        end
        tick();
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111) begin
            failures++;
            $display("FAIL store_resp loads=%b exp 11111", loads);
        end
        tick();
        set_idle();
    endtask

    task automatic test_ldi();
        // Cycle by cycle: {dmem_resp, exp ind_latch, exp mem_addr_sel, exp load_mem_wb}
        logic [3:0] vec [6];
        vec[0] = 4'b0000; vec[1] = 4'b0000; vec[2] = 4'b1100;
        vec[3] = 4'b0010; vec[4] = 4'b0010; vec[5] = 4'b1011;
        set_idle();
        mem_req = 1'b1; mem_indirect = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_resp = vec[i][3];
            #1;
            checks++;
            if ({ind_latch, mem_addr_sel, load_mem_wb, dmem_read, dmem_write} !== {vec[i][2:0], 2'b10}) begin
                failures++;
                $display("FAIL ldi_cycle%0d lat/sel/wb/rd/wr=%b exp %b", i,
                         {ind_latch, mem_addr_sel, load_mem_wb, dmem_read, dmem_write},
                         {vec[i][2:0], 2'b10});
            end
            tick();
        end
        set_idle();
        mem_req = 1'b1;
        #1;
        checks++;
        if (mem_addr_sel !== 1'b0) begin
            failures++;
            $display("FAIL ldi_return sel=%b exp 0", mem_addr_sel);
        end
        set_idle();
        tick();
    endtask

    task automatic test_sti();
        set_idle();
        mem_req = 1'b1; mem_indirect = 1'b1; mem_write = 1'b1;
        #1;
        checks++;
        if ({dmem_read, dmem_write, mem_addr_sel} !== 3'b100) begin
            failures++;
            $display("FAIL sti_first rd/wr/sel=%b exp 100", {dmem_read, dmem_write, mem_addr_sel});
        end
        tick();
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (ind_latch !== 1'b1 || loads !== 5'b00000) begin
            failures++;
            $display("FAIL sti_latch lat=%b loads=%b exp 1/00000", ind_latch, loads);
        end
        tick();
        dmem_resp = 1'b0;
        #1;
        checks++;
        if ({dmem_read, dmem_write, mem_addr_sel} !== 3'b011 || loads !== 5'b00000) begin
            failures++;
            $display("FAIL sti_second rd/wr/sel=%b loads=%b exp 011/00000",
                     {dmem_read, dmem_write, mem_addr_sel}, loads);
        end
        tick();
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111 || dmem_write !== 1'b1) begin
            failures++;
            $display("FAIL sti_done loads=%b wr=%b exp 11111/1", loads, dmem_write);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch_stall();
        set_idle();
        mem_req = 1'b1; br_taken = 1'b1;
        ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd2;
        id_sr1_id = 3'd2; id_uses_sr1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (loads !== 5'b00000 || flushes !== 3'b000 || pc_target_sel !== 1'b0) begin
                failures++;
                $display("FAIL br_stall%0d loads=%b flushes=%b pcsel=%b exp 00000/000/0",
                         i, loads, flushes, pc_target_sel);
            end
            tick();
        end
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111 || flushes !== 3'b111 || pc_target_sel !== 1'b1) begin
            failures++;
            $display("FAIL br_apply loads=%b flushes=%b pcsel=%b exp 11111/111/1",
                     loads, flushes, pc_target_sel);
        end
        tick();
        set_idle();
    endtask

    task automatic test_imem_stall();
        set_idle();
        imem_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (loads !== 5'b00000) begin
                failures++;
                $display("FAIL imem_stall%0d loads=%b exp 00000", i, loads);
            end
            tick();
        end
        imem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111) begin
            failures++;
            $display("FAIL imem_resp loads=%b exp 11111", loads);
        end
        tick();
        set_idle();
    endtask

    task automatic test_back_to_back();
        // Fetch still busy while the LDI pointer fetch completes.
        set_idle();
        imem_read = 1'b1; mem_req = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b00000 || ind_latch !== 1'b1) begin
            failures++;
            $display("FAIL overlap_first loads=%b lat=%b exp 00000/1", loads, ind_latch);
        end
        tick();
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (mem_addr_sel !== 1'b1 || ind_latch !== 1'b0 || dmem_read !== 1'b1) begin
            failures++;
            $display("FAIL overlap_second sel/lat/rd=%b exp 101", {mem_addr_sel, ind_latch, dmem_read});
        end
        tick();
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b00000) begin
            failures++;
            $display("FAIL overlap_imem_hold loads=%b exp 00000", loads);
        end
        tick();
        // FSM moved back on that response; the pipe now waits only on imem.
        mem_req = 1'b0; mem_indirect = 1'b0; dmem_resp = 1'b0; imem_resp = 1'b1;
        #1;
        checks++;
        if (loads !== 5'b11111 || mem_addr_sel !== 1'b0) begin
            failures++;
            $display("FAIL overlap_release loads=%b sel=%b exp 11111/0", loads, mem_addr_sel);
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_indirect();
        set_idle();
        mem_req = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if ({dmem_read, dmem_write, ind_latch} !== 3'b000 || loads !== 5'b00000) begin
            failures++;
            $display("FAIL rst_mid_strobes rd/wr/lat=%b loads=%b exp 000/00000",
                     {dmem_read, dmem_write, ind_latch}, loads);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_addr_sel !== 1'b0 || dmem_read !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_restart sel=%b rd=%b exp 0/1", mem_addr_sel, dmem_read);
        end
        set_idle();
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 16'd0 || bubble_count !== 16'd0) begin
            failures++;
            $display("FAIL perf_reset stall=%0d bubble=%0d exp 0/0", stall_cycles, bubble_count);
        end
        imem_read = 1'b1;
        repeat (3) tick();
        set_idle();
        ex_is_load = 1'b1; ex_load_regfile = 1'b1; id_uses_sr1 = 1'b1;
        tick();
        set_idle();
        br_taken = 1'b1;
        tick();
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 16'd3 || bubble_count !== 16'd2) begin
            failures++;
            $display("FAIL perf_count stall=%0d bubble=%0d exp 3/2", stall_cycles, bubble_count);
        end
        imem_read = 1'b1;
        repeat (70000) tick();
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            failures++;
            $display("FAIL perf_saturate stall=%h exp ffff", stall_cycles);
        end
        tick();
    endtask
`endif

    initial begin
        set_idle();
        rst = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_plain_access();
        test_ldi();
        test_sti();
        test_branch_stall();
        test_imem_stall();
        test_back_to_back();
        test_reset_mid_indirect();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
